// File: rtl/decode_pkg.sv
// Shared RV32I decode constants, control bundles and queue entry layout.
// Build option: define CSR_DECODE_EN to decode SYSTEM CSR instructions.
package decode_pkg;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_ALUI   = 7'b0010011;
    localparam logic [6:0] OPCODE_ALUR   = 7'b0110011;
    localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    // Control bundle bit positions.
    localparam int CTRL_VALID  = 0;
    localparam int CTRL_ALUOP  = 1;
    localparam int CTRL_TYPES  = 3;
    localparam int CTRL_PCADD  = 10;
    localparam int CTRL_ALUSRC = 11;
    localparam int CTRL_RESSEL = 12;
    localparam int CTRL_TOREG  = 14;
    localparam int CTRL_REGWR  = 15;
    localparam int CTRL_MEMWR  = 16;
    localparam int CTRL_MEMRD  = 17;
    localparam int CTRL_JUMP   = 18;
    localparam int CTRL_BRANCH = 20;

    // One-hot format bits inside types: {R,I,S,B,U,J,Z}.
    localparam int T_Z = 0;
    localparam int T_J = 1;
    localparam int T_U = 2;
    localparam int T_B = 3;
    localparam int T_S = 4;
    localparam int T_I = 5;
    localparam int T_R = 6;

    localparam logic [20:0] DEC_LUI    = 21'h09021;
    localparam logic [20:0] DEC_AUIPC  = 21'h08C21;
    localparam logic [20:0] DEC_JAL    = 21'h4A011;
    localparam logic [20:0] DEC_JALR   = 21'h8A901;
    localparam logic [20:0] DEC_BRANCH = 21'h100043;
    localparam logic [20:0] DEC_LOAD   = 21'h2C901;
    localparam logic [20:0] DEC_STORE  = 21'h10881;
    localparam logic [20:0] DEC_ALUI   = 21'h08905;
    localparam logic [20:0] DEC_ALUR   = 21'h08205;
    localparam logic [20:0] DEC_FENCE  = 21'h00001;
    localparam logic [20:0] DEC_CSR    = 21'h0B009;
    localparam logic [20:0] DEC_SYS    = 21'h00001;
    localparam logic [20:0] DEC_ILL    = 21'h00000;

    typedef struct packed {
        logic [20:0] ctrl;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [2:0]  csr_op;
    } decode_entry_t;

endpackage

// File: rtl/decode_fifo.sv
// Generic synchronous FIFO with async reset and synchronous flush.
// Head data reads as zero while empty; no input-to-output bypass.
module decode_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       pop_valid,
    input  logic                       pop_ready,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full, empty, push, pop;

    // Occupancy from extra-MSB pointers.
    always_comb begin
        empty      = (wr_q == rd_q);
        full       = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
        push_ready = !full;
        pop_valid  = !empty;
        push       = push_valid && !full;
        pop        = pop_ready && !empty;
        count      = wr_q - rd_q;
        pop_data   = empty ? '0 : mem_q[rd_q[AW-1:0]];
    end

    // Pointer next-state; flush wins over any handshake.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push) wr_d = wr_q + 1'b1;
            if (pop)  rd_d = rd_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage write; contents are don't-care until pointed at.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/decode_queue.sv
// Queued RV32I decode stage: decode on entry, buffer, present head.
// Build option: define CSR_DECODE_EN to decode SYSTEM CSR instructions.
module decode_queue
    import decode_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PC_W-1:0]         in_pc,
    input  logic [31:0]             in_instr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PC_W-1:0]         out_pc,
    output logic [20:0]             out_ctrl,
    output logic [31:0]             out_imm,
    output logic [4:0]              out_rs1,
    output logic [4:0]              out_rs2,
    output logic [4:0]              out_rd,
    output logic [2:0]              out_funct3,
    output logic                    out_funct7b5,
    output logic                    out_illegal,
    output logic [2:0]              out_csr_op,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int EW = $bits(decode_entry_t);

    logic [31:0]   ins;
    logic [6:0]    typ;
    decode_entry_t dec;
    decode_entry_t head;
    logic [PC_W+EW-1:0] head_raw;

    assign ins = in_instr;

    // Control bundle lookup; unknown opcodes leave an all-zero bundle.
    always_comb begin
        dec.ctrl   = DEC_ILL;
        dec.csr_op = 3'b000;
        case (ins[6:0])
            OPCODE_LUI:    dec.ctrl = DEC_LUI;
            OPCODE_AUIPC:  dec.ctrl = DEC_AUIPC;
            OPCODE_JAL:    dec.ctrl = DEC_JAL;
            OPCODE_JALR:   dec.ctrl = DEC_JALR;
            OPCODE_BRANCH: dec.ctrl = DEC_BRANCH;
            OPCODE_LOAD:   dec.ctrl = DEC_LOAD;
            OPCODE_STORE:  dec.ctrl = DEC_STORE;
            OPCODE_ALUI:   dec.ctrl = DEC_ALUI;
            OPCODE_ALUR:   dec.ctrl = DEC_ALUR;
            OPCODE_FENCE:  dec.ctrl = DEC_FENCE;
`ifdef CSR_DECODE_EN
            OPCODE_SYSTEM: begin
                if (ins[14:12] != 3'b000) begin
                    dec.ctrl   = DEC_CSR;
                    dec.csr_op = ins[14:12];
                end else begin
                    dec.ctrl   = DEC_SYS;
                end
            end
`endif
            default: ;
        endcase
        typ = dec.ctrl[CTRL_TYPES +: 7];
    end

    // Immediate and register fields keyed off the format one-hot.
    always_comb begin
        dec.imm = 32'h0;
        if (typ[T_I])
            dec.imm = {{20{ins[31]}}, ins[31:20]};
        else if (typ[T_S])
            dec.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        else if (typ[T_B])
            dec.imm = {{19{ins[31]}}, ins[31], ins[7],
                       ins[30:25], ins[11:8], 1'b0};
        else if (typ[T_U])
            dec.imm = {ins[31:12], 12'h000};
        else if (typ[T_J])
            dec.imm = {{11{ins[31]}}, ins[31], ins[19:12],
                       ins[20], ins[30:21], 1'b0};
        else if (typ[T_Z])
            dec.imm = {27'h0, ins[19:15]};
        dec.rs1 = (typ[T_R] | typ[T_I] | typ[T_S] | typ[T_B] | typ[T_Z])
                  ? ins[19:15] : 5'd0;
        dec.rs2 = (typ[T_R] | typ[T_S] | typ[T_B]) ? ins[24:20] : 5'd0;
        dec.rd  = (typ[T_R] | typ[T_I] | typ[T_U] | typ[T_J] | typ[T_Z])
                  ? ins[11:7] : 5'd0;
        dec.funct3   = ins[14:12];
        dec.funct7b5 = ins[30];
    end

    decode_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PC_W + EW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  ({in_pc, dec}),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (head_raw),
        .count      (count)
    );

    // Unpack the head entry onto the execute-side ports.
    always_comb begin
        out_pc       = head_raw[PC_W+EW-1:EW];
        head         = head_raw[EW-1:0];
        out_ctrl     = head.ctrl;
        out_imm      = head.imm;
        out_rs1      = head.rs1;
        out_rs2      = head.rs2;
        out_rd       = head.rd;
        out_funct3   = head.funct3;
        out_funct7b5 = head.funct7b5;
        out_csr_op   = head.csr_op;
        out_illegal  = out_valid && !head.ctrl[CTRL_VALID];
    end

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue (DEPTH=4, PC_W=32).
// Honours CSR_DECODE_EN the same way as the design.
module tb_decode_queue;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] in_pc, in_instr, out_pc, out_imm;
    logic [20:0] out_ctrl;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  out_funct3, out_csr_op;
    logic        out_funct7b5, out_illegal;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(4), .PC_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_ctrl     (out_ctrl),
        .out_imm      (out_imm),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_rd       (out_rd),
        .out_funct3   (out_funct3),
        .out_funct7b5 (out_funct7b5),
        .out_illegal  (out_illegal),
        .out_csr_op   (out_csr_op),
        .count        (count)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] ins);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = ins;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_count", {29'h0, count}, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_ctrl", {11'h0, out_ctrl}, 32'h0);
        step();
        rst = 1'b0;
        step();

        // LUI x1, 0x12345
        push_one(32'h100, 32'h123450B7);
        chk("lui_valid", {31'h0, out_valid}, 32'h1);
        chk("lui_rd", {27'h0, out_rd}, 32'h1);
        chk("lui_imm", out_imm, 32'h12345000);
        chk("lui_ressel", {30'h0, out_ctrl[13:12]}, 32'h1);
        chk("lui_types", {25'h0, out_ctrl[9:3]}, 32'h4);
        chk("lui_ctrl", {11'h0, out_ctrl}, 32'h09021);
        chk("lui_pc", out_pc, 32'h100);
        pop_one();
        chk("lui_popped", {29'h0, count}, 32'h0);
        chk("lui_empty", {31'h0, out_valid}, 32'h0);

        // ADDI x1, x0, -1
        push_one(32'h104, 32'hFFF00093);
        chk("addi_imm", out_imm, 32'hFFFFFFFF);
        chk("addi_ctrl", {11'h0, out_ctrl}, 32'h08905);
        chk("addi_rs1", {27'h0, out_rs1}, 32'h0);
        chk("addi_rs2", {27'h0, out_rs2}, 32'h0);
        chk("addi_rd", {27'h0, out_rd}, 32'h1);
        pop_one();

        // BEQ x0, x0, -4
        push_one(32'h108, 32'hFE000EE3);
        chk("beq_imm", out_imm, 32'hFFFFFFFC);
        chk("beq_ctrl", {11'h0, out_ctrl}, 32'h100043);
        chk("beq_rd", {27'h0, out_rd}, 32'h0);
        pop_one();

        // JAL x1, 8
        push_one(32'h10C, 32'h008000EF);
        chk("jal_imm", out_imm, 32'h8);
        chk("jal_ctrl", {11'h0, out_ctrl}, 32'h4A011);
        chk("jal_rd", {27'h0, out_rd}, 32'h1);
        pop_one();

        // SW x1, 4(x2)
        push_one(32'h110, 32'h00112223);
        chk("sw_imm", out_imm, 32'h4);
        chk("sw_ctrl", {11'h0, out_ctrl}, 32'h10881);
        chk("sw_rs1", {27'h0, out_rs1}, 32'h2);
        chk("sw_rs2", {27'h0, out_rs2}, 32'h1);
        chk("sw_rd", {27'h0, out_rd}, 32'h0);
        chk("sw_f3", {29'h0, out_funct3}, 32'h2);
        pop_one();

        // Fill to full, hold a fifth, then one pop.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h200 + 32'(4 * i);
            in_instr = 32'hFFF00093;
            step();
        end
        chk("full_count", {29'h0, count}, 32'h4);
        chk("full_ready", {31'h0, in_ready}, 32'h0);
        in_pc = 32'h210;
        step();
        chk("held_count", {29'h0, count}, 32'h4);
        chk("held_head", out_pc, 32'h200);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pop_count", {29'h0, count}, 32'h3);
        chk("pop_ready", {31'h0, in_ready}, 32'h1);
        chk("pop_head", out_pc, 32'h204);
        step();
        in_valid = 1'b0;
        chk("refill_count", {29'h0, count}, 32'h4);
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", out_pc, 32'h204 + 32'(4 * i));
            pop_one();
        end
        chk("drain_empty", {29'h0, count}, 32'h0);

        // Continuous push+pop streaming.
        push_one(32'h300, 32'h00000013);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_pc = 32'h300 + 32'(4 * (k + 1));
            chk("stream_pc", out_pc, 32'h300 + 32'(4 * k));
            chk("stream_count", {29'h0, count}, 32'h1);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("stream_last", out_pc, 32'h350);
        pop_one();
        chk("stream_empty", {29'h0, count}, 32'h0);

        // Flush with three queued and a push offered.
        push_one(32'h400, 32'h00000013);
        push_one(32'h404, 32'h00000013);
        push_one(32'h408, 32'h00000013);
        chk("pre_flush", {29'h0, count}, 32'h3);
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_pc = 32'h4FC;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("flush_count", {29'h0, count}, 32'h0);
        chk("flush_valid", {31'h0, out_valid}, 32'h0);
        chk("flush_pc", out_pc, 32'h0);
        step();
        chk("flush_after", {29'h0, count}, 32'h0);

        // CSRRW x1, 0x300, x2
        push_one(32'h500, 32'h300110F3);
`ifdef CSR_DECODE_EN
        chk("csr_op", {29'h0, out_csr_op}, 32'h1);
        chk("csr_ctrl", {11'h0, out_ctrl}, 32'h0B009);
        chk("csr_illegal", {31'h0, out_illegal}, 32'h0);
        chk("csr_imm", out_imm, 32'h2);
`else
        chk("csr_illegal", {31'h0, out_illegal}, 32'h1);
        chk("csr_op", {29'h0, out_csr_op}, 32'h0);
        chk("csr_ctrl", {11'h0, out_ctrl}, 32'h0);
`endif
        pop_one();

        // All-zero word is illegal but still queued.
        push_one(32'h504, 32'h00000000);
        chk("zero_valid", {31'h0, out_valid}, 32'h1);
        chk("zero_illegal", {31'h0, out_illegal}, 32'h1);
        chk("zero_ctrl", {11'h0, out_ctrl}, 32'h0);
        pop_one();

        // FENCE decodes as a NOP.
        push_one(32'h508, 32'h0FF0000F);
        chk("fence_ctrl", {11'h0, out_ctrl}, 32'h1);
        chk("fence_imm", out_imm, 32'h0);
        chk("fence_illegal", {31'h0, out_illegal}, 32'h0);

        // Asynchronous reset between clock edges.
        push_one(32'h50C, 32'h00000013);
        chk("prerst_count", {29'h0, count}, 32'h2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'h0, out_valid}, 32'h0);
        chk("arst_count", {29'h0, count}, 32'h0);
        chk("arst_ready", {31'h0, in_ready}, 32'h1);
        step();
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
